// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   MD_* operation codes driven by decode, iteration count, FSM state codes,
//   the per-sequence context latched at start, and small operand helpers.
package muldiv_unit_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int unsigned MD_ITER  = 32;
    localparam int unsigned MD_CNT_W = $clog2(MD_ITER);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Context captured when a sequence starts, consumed in FIX.
    typedef struct packed {
        logic is_div;   // divide sequence (else multiply)
        logic neg_res;  // negate product / quotient
        logic neg_rem;  // negate remainder (dividend was negative)
        logic div0;     // divisor was zero
    } md_ctx_t;

    // Ops that launch a 32-iteration sequence.
    function automatic logic md_is_seq(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Codes 7 and above behave as MD_NONE.
    function automatic logic md_is_active(input logic [2:0] op);
        return (op != MD_NONE) && (op <= MD_MTLO);
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: execute-stage <-> muldiv_unit connection.
//   md_op, hilo_rd, rs_val, rt_val : execute -> unit
//   hi, lo, busy, stall            : unit -> execute / hazard logic
interface muldiv_unit_if;
    logic [2:0]  md_op;
    logic        hilo_rd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    modport master (
        output md_op, hilo_rd, rs_val, rt_val,
        input  hi, lo, busy, stall
    );

    modport slave (
        input  md_op, hilo_rd, rs_val, rt_val,
        output hi, lo, busy, stall
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide sequencer owning HI/LO.
//   clk   : core clock, rising edge
//   rst   : synchronous active-high reset
//   md    : slave side of muldiv_unit_if
//           md_op/rs_val/rt_val select MULT/MULTU/DIV/DIVU/MTHI/MTLO,
//           hilo_rd flags MFHI/MFLO in execute,
//           hi/lo are the architectural registers, busy = sequence in flight,
//           stall (combinational) holds execute and earlier stages.
// Sequence: IDLE accepts an op, RUN does 32 shift-add / restoring-divide
// steps on magnitudes, FIX applies signs and writes HI/LO.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  md
);

    logic [1:0]          state;
    logic [MD_CNT_W-1:0] cnt;
    logic [63:0]         work;   // product, or remainder:quotient
    logic [31:0]         opnd;   // multiplicand or divisor magnitude
    md_ctx_t             ctx;
    logic [31:0]         hi_r;
    logic [31:0]         lo_r;

    logic        op_signed;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_rem;
    logic [32:0] div_diff;
    logic [63:0] div_next;

    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign md.hi    = hi_r;
    assign md.lo    = lo_r;
    assign md.busy  = (state != ST_IDLE);
    assign md.stall = md.busy && (md.hilo_rd || md_is_active(md.md_op));

    always_comb begin
        op_signed = (md.md_op == MD_MULT) || (md.md_op == MD_DIV);
        rs_mag    = mag32(md.rs_val, op_signed);
        rt_mag    = mag32(md.rt_val, op_signed);
    end

    // One iteration of each algorithm. The multiplier sits in work[31:0] and
    // is shifted out as product bits shift in; the dividend likewise shifts
    // out of work[31:0] while quotient bits shift in.
    always_comb begin
        mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
        mul_next = {mul_sum, work[31:1]};

        div_rem  = work[63:31];
        div_diff = div_rem - {1'b0, opnd};
        // A borrow out of bit 32 means the partial remainder was smaller.
        div_next = div_diff[32] ? {work[62:0], 1'b0}
                                : {div_diff[31:0], work[30:0], 1'b1};
    end

    always_comb begin
        prod_fix = ctx.neg_res ? (64'd0 - work) : work;
        quo_fix  = ctx.neg_res ? (32'd0 - work[31:0]) : work[31:0];
        rem_fix  = ctx.neg_rem ? (32'd0 - work[63:32]) : work[63:32];
        if (ctx.is_div) begin
            // Zero divisor leaves remainder = |rs|; re-signing gives rs back.
            res_hi = rem_fix;
            res_lo = ctx.div0 ? '1 : quo_fix;
        end else begin
            res_hi = prod_fix[63:32];
            res_lo = prod_fix[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            work  <= '0;
            opnd  <= '0;
            ctx   <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (md_is_seq(md.md_op)) begin
                        work        <= {32'd0, rs_mag};
                        opnd        <= rt_mag;
                        ctx.is_div  <= (md.md_op == MD_DIV) || (md.md_op == MD_DIVU);
                        ctx.neg_res <= op_signed && (md.rs_val[31] ^ md.rt_val[31]);
                        ctx.neg_rem <= (md.md_op == MD_DIV) && md.rs_val[31];
                        ctx.div0    <= (md.rt_val == 32'd0);
                        cnt         <= MD_CNT_W'(MD_ITER - 1);
                        state       <= ST_RUN;
                    end else if (md.md_op == MD_MTHI) begin
                        hi_r <= md.rs_val;
                    end else if (md.md_op == MD_MTLO) begin
                        lo_r <= md.rs_val;
                    end
                end
                ST_RUN: begin
                    work <= ctx.is_div ? div_next : mul_next;
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    hi_r  <= res_hi;
                    lo_r  <= res_lo;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .md  (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge in IDLE; returns on the falling edge of N+34.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int unsigned cycles;
        bus.md_op  = op;
        bus.rs_val = a;
        bus.rt_val = b;
        #1;
        check_eq({tag, "_start_stall"}, 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.md_op = MD_NONE;
        cycles = 0;
        while (bus.busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        check_eq({tag, "_busy_cycles"}, 64'(cycles), 64'd33);
        check_eq({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check_eq({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int unsigned cycles;
        rst         = 1'b1;
        bus.md_op   = MD_NONE;
        bus.hilo_rd = 1'b1;
        bus.rs_val  = '0;
        bus.rt_val  = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_hi",    64'(bus.hi),    64'd0);
        check_eq("reset_lo",    64'(bus.lo),    64'd0);
        check_eq("reset_busy",  64'(bus.busy),  64'd0);
        check_eq("reset_stall", 64'(bus.stall), 64'd0);
        rst         = 1'b0;
        bus.hilo_rd = 1'b0;

        // MTLO in IDLE: visible next cycle, never busy or stalling
        @(negedge clk);
        bus.md_op  = MD_MTLO;
        bus.rs_val = 32'hA5A5_A5A5;
        #1;
        check_eq("mtlo_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.md_op = MD_NONE;
        check_eq("mtlo_lo",   64'(bus.lo),   64'hA5A5_A5A5);
        check_eq("mtlo_hi",   64'(bus.hi),   64'd0);
        check_eq("mtlo_busy", 64'(bus.busy), 64'd0);

        // Back-to-back sequences, each started at the previous one's N+34
        run_op("multu_max",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",   MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult_big",   MD_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
        run_op("div_neg",    MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero",  MD_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div_zero",   MD_DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_op("div_ovf",    MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_basic", MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
        run_op("div_mixed",  MD_DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2);

        // MFHI from N+5 and a queued MULT from N+10, both released at N+34
        bus.md_op  = MD_MULTU;
        bus.rs_val = 32'd6;
        bus.rt_val = 32'd7;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 1) bus.md_op = MD_NONE;
            if (c == 5) bus.hilo_rd = 1'b1;
            if (c == 10) begin
                bus.md_op  = MD_MULT;
                bus.rs_val = 32'hFFFF_FFFE;
                bus.rt_val = 32'd3;
            end
            #1;
            check_eq($sformatf("hold_busy_c%0d", c),  64'(bus.busy),  64'd1);
            check_eq($sformatf("hold_stall_c%0d", c), 64'(bus.stall), (c >= 5) ? 64'd1 : 64'd0);
        end
        @(negedge clk);
        #1;
        check_eq("hold_release_busy",  64'(bus.busy),  64'd0);
        check_eq("hold_release_stall", 64'(bus.stall), 64'd0);
        check_eq("hold_mfhi_hi",       64'(bus.hi),    64'd0);
        check_eq("hold_mflo_lo",       64'(bus.lo),    64'd42);
        @(negedge clk);
        bus.md_op   = MD_NONE;
        bus.hilo_rd = 1'b0;
        cycles = 0;
        while (bus.busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        check_eq("queued_mult_busy_cycles", 64'(cycles), 64'd33);
        check_eq("queued_mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check_eq("queued_mult_lo", 64'(bus.lo), 64'hFFFF_FFFA);

        // MTHI during RUN is held off and leaves hi untouched until accepted
        bus.md_op  = MD_DIVU;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd7;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 1) bus.md_op = MD_NONE;
            if (c == 3) begin
                bus.md_op  = MD_MTHI;
                bus.rs_val = 32'hDEAD_BEEF;
            end
            #1;
            if (c >= 3) begin
                check_eq($sformatf("mthi_stall_c%0d", c), 64'(bus.stall), 64'd1);
                check_eq($sformatf("mthi_hi_c%0d", c),    64'(bus.hi),    64'hFFFF_FFFF);
            end
        end
        @(negedge clk);
        #1;
        check_eq("mthi_release_stall", 64'(bus.stall), 64'd0);
        check_eq("mthi_divu_hi",       64'(bus.hi),    64'd2);
        check_eq("mthi_divu_lo",       64'(bus.lo),    64'd14);
        @(negedge clk);
        bus.md_op = MD_NONE;
        check_eq("mthi_applied_hi", 64'(bus.hi),   64'hDEAD_BEEF);
        check_eq("mthi_applied_lo", 64'(bus.lo),   64'd14);
        check_eq("mthi_no_busy",    64'(bus.busy), 64'd0);

        // Reset at N+15 of a DIVU discards it; a MULTU right after is correct
        bus.md_op  = MD_DIVU;
        bus.rs_val = 32'hFFFF_0000;
        bus.rt_val = 32'd3;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) bus.md_op = MD_NONE;
            if (c == 15) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_mid_busy",  64'(bus.busy),  64'd0);
        check_eq("rst_mid_stall", 64'(bus.stall), 64'd0);
        check_eq("rst_mid_hi",    64'(bus.hi),    64'd0);
        check_eq("rst_mid_lo",    64'(bus.lo),    64'd0);
        run_op("post_rst_multu", MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
